// File: rtl/write_buffer_if.sv
// rtl/write_buffer_if.sv - cache-side write, forwarding lookup and memory drain signals of write_buffer
interface write_buffer_if #(
    parameter int DEPTH     = 4,
    parameter int ADDR_SIZE = 15,
    parameter int WORD_SIZE = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                 wr_req;
    logic [ADDR_SIZE-1:0] wr_address;
    logic [WORD_SIZE-1:0] wr_data;
    logic                 wr_ready;
    logic [ADDR_SIZE-1:0] rd_address;
    logic                 fwd_hit;
    logic [WORD_SIZE-1:0] fwd_data;
    logic                 mem_write;
    logic [ADDR_SIZE-1:0] mem_address;
    logic [WORD_SIZE-1:0] mem_data;
    logic                 mem_ack;
    logic [CNT_W-1:0]     count;
    logic                 empty;

    modport slave (
        input  wr_req, wr_address, wr_data, rd_address, mem_ack,
        output wr_ready, fwd_hit, fwd_data, mem_write, mem_address, mem_data, count, empty
    );

    modport master (
        output wr_req, wr_address, wr_data, rd_address, mem_ack,
        input  wr_ready, fwd_hit, fwd_data, mem_write, mem_address, mem_data, count, empty
    );
endinterface

// File: rtl/write_buffer.sv
// rtl/write_buffer.sv - circular write buffer draining to memory with read-miss forwarding
// Optional feature: define WRITE_COALESCE_EN to merge writes into matching non-draining entries.
module write_buffer #(
    parameter int DEPTH     = 4,
    parameter int ADDR_SIZE = 15,
    parameter int WORD_SIZE = 32
) (
    input  logic           clk,
    input  logic           rst,
    write_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t               state_q;
    logic [ADDR_SIZE-1:0] entry_addr_q [DEPTH];
    logic [WORD_SIZE-1:0] entry_data_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 mem_write_q;
    logic [ADDR_SIZE-1:0] mem_address_q, head_addr_d;
    logic [WORD_SIZE-1:0] mem_data_q, head_data_d;

    logic                 merge_hit;
    logic [PTR_W-1:0]     merge_idx;
    logic                 wr_ready;
    logic                 accept, push, pop;
    logic [PTR_W-1:0]     ram_idx;
    logic                 fwd_hit;
    logic [WORD_SIZE-1:0] fwd_data;

    // Age-ordered scan (oldest first) so the last match is the newest entry.
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (entry_addr_q[idx] == bus.rd_address)) begin
                fwd_hit  = 1'b1;
                fwd_data = entry_data_q[idx];
            end
        end
    end

`ifdef WRITE_COALESCE_EN
    // The head is excluded while it is on the memory bus so its data stays stable.
    always_comb begin
        logic [PTR_W-1:0] idx;
        merge_hit = 1'b0;
        merge_idx = '0;
        idx       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (entry_addr_q[idx] == bus.wr_address)
                && !((state_q == WRITE) && (k == 0))) begin
                merge_hit = 1'b1;
                merge_idx = idx;
            end
        end
    end
`else
    assign merge_hit = 1'b0;
    assign merge_idx = '0;
`endif

    assign wr_ready = (count_q < CNT_W'(DEPTH)) || merge_hit;
    assign accept   = bus.wr_req && wr_ready;
    assign push     = accept && !merge_hit;
    assign pop      = mem_write_q && bus.mem_ack;
    assign ram_idx  = merge_hit ? merge_idx : wr_ptr_q;

    assign wr_ptr_d = wr_ptr_q + PTR_W'(push);
    assign rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    // Head entry as it will look after this edge, bypassing a same-cycle RAM write.
    always_comb begin
        head_addr_d = entry_addr_q[rd_ptr_d];
        head_data_d = entry_data_q[rd_ptr_d];
        if (accept && (ram_idx == rd_ptr_d)) begin
            head_addr_d = bus.wr_address;
            head_data_d = bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            entry_addr_q[ram_idx] <= bus.wr_address;
            entry_data_q[ram_idx] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            case (state_q)
                IDLE: begin
                    if (count_d != '0) begin
                        state_q       <= WRITE;
                        mem_write_q   <= 1'b1;
                        mem_address_q <= head_addr_d;
                        mem_data_q    <= head_data_d;
                    end
                end
                WRITE: begin
                    if (pop) begin
                        if (count_d != '0) begin
                            mem_address_q <= head_addr_d;
                            mem_data_q    <= head_data_d;
                        end else begin
                            state_q       <= IDLE;
                            mem_write_q   <= 1'b0;
                            mem_address_q <= '0;
                            mem_data_q    <= '0;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.wr_ready    = wr_ready;
    assign bus.fwd_hit     = fwd_hit;
    assign bus.fwd_data    = fwd_data;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_data    = mem_data_q;
    assign bus.count       = count_q;
    assign bus.empty       = (count_q == '0);
endmodule

// File: tb/tb_write_buffer.sv
// tb/tb_write_buffer.sv - directed self-checking bench for write_buffer
module tb_write_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 15;
    localparam int DW    = 32;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    write_buffer_if #(.DEPTH(DEPTH), .ADDR_SIZE(AW), .WORD_SIZE(DW)) bus();

    write_buffer #(.DEPTH(DEPTH), .ADDR_SIZE(AW), .WORD_SIZE(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs;
        bus.wr_req     = 1'b0;
        bus.wr_address = '0;
        bus.wr_data    = '0;
        bus.rd_address = '0;
        bus.mem_ack    = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%0b exp=1", bus.wr_ready); end
        checks++; if (bus.mem_write !== 1'b0) begin failures++; $display("FAIL reset_mem_write got=%0b exp=0", bus.mem_write); end
        checks++; if (bus.mem_address !== 15'h0) begin failures++; $display("FAIL reset_mem_address got=%0h exp=0", bus.mem_address); end
        checks++; if (bus.mem_data !== 32'h0) begin failures++; $display("FAIL reset_mem_data got=%0h exp=0", bus.mem_data); end
        checks++; if (bus.fwd_hit !== 1'b0) begin failures++; $display("FAIL reset_fwd_hit got=%0b exp=0", bus.fwd_hit); end
        checks++; if (bus.fwd_data !== 32'h0) begin failures++; $display("FAIL reset_fwd_data got=%0h exp=0", bus.fwd_data); end
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", bus.empty); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single;
        @(negedge clk);
        bus.wr_req = 1'b1; bus.wr_address = 15'h0010; bus.wr_data = 32'hDEADBEEF; bus.mem_ack = 1'b1;
        #1;
        checks++; if (bus.mem_write !== 1'b0) begin failures++; $display("FAIL single_pre_write got=%0b exp=0", bus.mem_write); end
        @(negedge clk);
        bus.wr_req = 1'b0;
        #1;
        checks++; if (bus.mem_write !== 1'b1) begin failures++; $display("FAIL single_mem_write got=%0b exp=1", bus.mem_write); end
        checks++; if (bus.mem_address !== 15'h0010) begin failures++; $display("FAIL single_mem_address got=%0h exp=10", bus.mem_address); end
        checks++; if (bus.mem_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_mem_data got=%0h exp=deadbeef", bus.mem_data); end
        @(negedge clk);
        #1;
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL single_empty got=%0b exp=1", bus.empty); end
        checks++; if (bus.mem_write !== 1'b0) begin failures++; $display("FAIL single_done got=%0b exp=0", bus.mem_write); end
        bus.mem_ack = 1'b0;
    endtask

    task automatic test_fill;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            bus.wr_req = 1'b1; bus.wr_address = AW'(i); bus.wr_data = DW'(32'h100 + i);
        end
        @(negedge clk);
        bus.wr_address = 15'd5; bus.wr_data = 32'h105;
        #1;
        checks++; if (bus.count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", bus.count); end
        checks++; if (bus.wr_ready !== 1'b0) begin failures++; $display("FAIL fill_wr_ready got=%0b exp=0", bus.wr_ready); end
        @(negedge clk);
        bus.wr_req = 1'b0;
        #1;
        checks++; if (bus.count !== 3'd4) begin failures++; $display("FAIL fill_fifth_ignored got=%0d exp=4", bus.count); end
        for (int i = 1; i <= 4; i++) begin
            bus.mem_ack = 1'b1;
            #1;
            checks++; if (bus.mem_write !== 1'b1) begin failures++; $display("FAIL fill_drain_write%0d got=%0b exp=1", i, bus.mem_write); end
            checks++; if (bus.mem_address !== AW'(i)) begin failures++; $display("FAIL fill_drain_addr%0d got=%0h exp=%0h", i, bus.mem_address, i); end
            checks++; if (bus.mem_data !== DW'(32'h100 + i)) begin failures++; $display("FAIL fill_drain_data%0d got=%0h exp=%0h", i, bus.mem_data, 32'h100 + i); end
            @(negedge clk);
        end
        bus.mem_ack = 1'b0;
        #1;
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL fill_empty got=%0b exp=1", bus.empty); end
        checks++; if (bus.mem_write !== 1'b0) begin failures++; $display("FAIL fill_idle got=%0b exp=0", bus.mem_write); end
    endtask

    task automatic test_forward;
        @(negedge clk);
        bus.wr_req = 1'b1; bus.wr_address = 15'h0005; bus.wr_data = 32'h11; bus.rd_address = 15'h0005;
        #1;
        checks++; if (bus.fwd_hit !== 1'b0) begin failures++; $display("FAIL fwd_not_yet got=%0b exp=0", bus.fwd_hit); end
        @(negedge clk);
        bus.wr_data = 32'h22;
        #1;
        checks++; if (bus.fwd_hit !== 1'b1) begin failures++; $display("FAIL fwd_first_hit got=%0b exp=1", bus.fwd_hit); end
        checks++; if (bus.fwd_data !== 32'h11) begin failures++; $display("FAIL fwd_first_data got=%0h exp=11", bus.fwd_data); end
        @(negedge clk);
        bus.wr_req = 1'b0;
        #1;
        checks++; if (bus.fwd_data !== 32'h22) begin failures++; $display("FAIL fwd_newest got=%0h exp=22", bus.fwd_data); end
        checks++; if (bus.count !== 3'd2) begin failures++; $display("FAIL fwd_count got=%0d exp=2", bus.count); end
        bus.rd_address = 15'h0006;
        #1;
        checks++; if (bus.fwd_hit !== 1'b0) begin failures++; $display("FAIL fwd_miss_hit got=%0b exp=0", bus.fwd_hit); end
        checks++; if (bus.fwd_data !== 32'h0) begin failures++; $display("FAIL fwd_miss_data got=%0h exp=0", bus.fwd_data); end
        bus.rd_address = 15'h0005; bus.mem_ack = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (bus.fwd_hit !== 1'b1) begin failures++; $display("FAIL fwd_draining_hit got=%0b exp=1", bus.fwd_hit); end
        checks++; if (bus.fwd_data !== 32'h22) begin failures++; $display("FAIL fwd_draining_data got=%0h exp=22", bus.fwd_data); end
        @(negedge clk);
        #1;
        checks++; if (bus.fwd_hit !== 1'b0) begin failures++; $display("FAIL fwd_popped got=%0b exp=0", bus.fwd_hit); end
        bus.mem_ack = 1'b0; bus.rd_address = '0;
    endtask

    task automatic test_full_collision;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            bus.wr_req = 1'b1; bus.wr_address = AW'(32'h20 + i); bus.wr_data = DW'(32'hA0 + i);
        end
        @(negedge clk);
        bus.wr_address = 15'h0030; bus.wr_data = 32'hBAD; bus.mem_ack = 1'b1; bus.rd_address = 15'h0030;
        #1;
        checks++; if (bus.wr_ready !== 1'b0) begin failures++; $display("FAIL full_wr_ready got=%0b exp=0", bus.wr_ready); end
        checks++; if (bus.mem_address !== 15'h0021) begin failures++; $display("FAIL full_head got=%0h exp=21", bus.mem_address); end
        @(negedge clk);
        bus.wr_req = 1'b0;
        #1;
        checks++; if (bus.count !== 3'd3) begin failures++; $display("FAIL full_pop_only got=%0d exp=3", bus.count); end
        checks++; if (bus.fwd_hit !== 1'b0) begin failures++; $display("FAIL full_not_stored got=%0b exp=0", bus.fwd_hit); end
        for (int i = 2; i <= 4; i++) begin
            checks++; if (bus.mem_address !== AW'(32'h20 + i)) begin failures++; $display("FAIL full_drain_addr%0d got=%0h exp=%0h", i, bus.mem_address, 32'h20 + i); end
            @(negedge clk);
            #1;
        end
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL full_empty got=%0b exp=1", bus.empty); end
        bus.mem_ack = 1'b0; bus.rd_address = '0;
    endtask

    task automatic test_reset_mid_drain;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            bus.wr_req = 1'b1; bus.wr_address = AW'(32'h50 + i); bus.wr_data = DW'(i);
        end
        @(negedge clk);
        bus.wr_req = 1'b0;
        #1;
        checks++; if (bus.count !== 3'd3) begin failures++; $display("FAIL rmd_count got=%0d exp=3", bus.count); end
        checks++; if (bus.mem_write !== 1'b1) begin failures++; $display("FAIL rmd_write got=%0b exp=1", bus.mem_write); end
        #1;
        rst = 1'b0;
        #1;
        checks++; if (bus.mem_write !== 1'b0) begin failures++; $display("FAIL rmd_async_write got=%0b exp=0", bus.mem_write); end
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL rmd_async_count got=%0d exp=0", bus.count); end
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL rmd_async_empty got=%0b exp=1", bus.empty); end
        checks++; if (bus.mem_address !== 15'h0) begin failures++; $display("FAIL rmd_async_addr got=%0h exp=0", bus.mem_address); end
        @(negedge clk);
        rst = 1'b1; bus.mem_ack = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL rmd_late_ack_count got=%0d exp=0", bus.count); end
        checks++; if (bus.mem_write !== 1'b0) begin failures++; $display("FAIL rmd_late_ack_write got=%0b exp=0", bus.mem_write); end
        bus.mem_ack = 1'b0;
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.wr_req = 1'b1; bus.wr_address = AW'(32'h40 + i); bus.wr_data = DW'(32'hC000 + i); bus.mem_ack = 1'b1;
            #1;
            if (i > 0) begin
                checks++; if (bus.mem_address !== AW'(32'h40 + i - 1)) begin failures++; $display("FAIL b2b_addr%0d got=%0h exp=%0h", i - 1, bus.mem_address, 32'h40 + i - 1); end
                checks++; if (bus.mem_data !== DW'(32'hC000 + i - 1)) begin failures++; $display("FAIL b2b_data%0d got=%0h exp=%0h", i - 1, bus.mem_data, 32'hC000 + i - 1); end
                checks++; if (bus.count !== 3'd1) begin failures++; $display("FAIL b2b_count%0d got=%0d exp=1", i - 1, bus.count); end
            end else begin
                checks++; if (bus.mem_write !== 1'b0) begin failures++; $display("FAIL b2b_start got=%0b exp=0", bus.mem_write); end
            end
        end
        @(negedge clk);
        bus.wr_req = 1'b0;
        #1;
        checks++; if (bus.mem_address !== 15'h0049) begin failures++; $display("FAIL b2b_last_addr got=%0h exp=49", bus.mem_address); end
        checks++; if (bus.mem_data !== 32'hC009) begin failures++; $display("FAIL b2b_last_data got=%0h exp=c009", bus.mem_data); end
        @(negedge clk);
        #1;
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL b2b_empty got=%0b exp=1", bus.empty); end
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_forward();
        test_full_collision();
        test_reset_mid_drain();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/write_buffer.md
WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered word writes (power of 2, 2..16).
REQ-002 Parameter ADDR_SIZE, default 15, word address width.
REQ-003 Parameter WORD_SIZE, default 32, data word width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 wr_req  input  1  cache-side write request, qualified by wr_ready.
REQ-007 wr_address  input  ADDR_SIZE  cache-side write word address.
REQ-008 wr_data  input  WORD_SIZE  cache-side write data.
REQ-009 wr_ready  output  1  buffer can accept a write this cycle.
REQ-010 rd_address  input  ADDR_SIZE  cache read-miss address for forwarding lookup.
REQ-011 fwd_hit  output  1  rd_address matches a buffered entry.
REQ-012 fwd_data  output  WORD_SIZE  data of the newest matching entry, zero when fwd_hit=0.
REQ-013 mem_write  output  1  memory write request, held until mem_ack.
REQ-014 mem_address  output  ADDR_SIZE  address of the entry being drained.
REQ-015 mem_data  output  WORD_SIZE  data of the entry being drained.
REQ-016 mem_ack  input  1  memory accepted the write this cycle.
REQ-017 count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-018 empty  output  1  count == 0.

Function
REQ-019 Storage is a circular FIFO of DEPTH entries {address, data} with write pointer, read pointer and count; pointers wrap modulo DEPTH.
REQ-020 wr_ready = (count < DEPTH); a write is accepted when wr_req && wr_ready; wr_req while full is ignored, no state change.
REQ-021 Drain FSM states: IDLE, WRITE. IDLE -> WRITE when count > 0; in WRITE, mem_write=1 with head-entry address/data held stable; on mem_ack pop head, then WRITE if count after pop > 0, else IDLE.
REQ-022 Minimum drain latency: entry accepted in cycle N drives mem_write=1 in cycle N+1 when buffer was empty; mem_ack in the same cycle as first mem_write assertion completes the transfer.
REQ-023 Simultaneous accept and pop in one cycle: count unchanged, both pointers advance; accept is permitted when full only if... not permitted: wr_ready reflects registered count, so no push when full even if pop occurs.
REQ-024 mem_ack while mem_write=0 is ignored.
REQ-025 fwd_hit/fwd_data combinational from rd_address over all valid entries; on multiple matches newest (closest to write pointer) wins; an entry being drained still forwards until popped.
REQ-026 An entry accepted in cycle N is visible to forwarding from cycle N+1.

Reset
REQ-027 rst low asynchronously clears pointers and count, FSM to IDLE; outputs: wr_ready=1, mem_write=0, mem_address=0, mem_data=0, fwd_hit=0, fwd_data=0, count=0, empty=1.
REQ-028 Reset mid-drain abandons the in-flight write; stored entries are discarded; entry RAM contents need not be cleared.

Configuration
REQ-029 Macro WRITE_COALESCE_EN: when defined, an accepted write whose address matches a valid entry other than the head while in WRITE (head may merge when IDLE) overwrites that entry's data, count unchanged; accept allowed even when full if such a match exists (wr_ready = count<DEPTH || match).
REQ-030 Without WRITE_COALESCE_EN every accepted write allocates a new entry; no address compare on the write path.

Verification
REQ-031 Reset, write 0x0010/0xDEADBEEF, mem_ack held 1 -> mem_write in next cycle with 0x0010/0xDEADBEEF, empty=1 one cycle after ack.
REQ-032 Four writes addr 1..4 with mem_ack=0 -> count=4, wr_ready=0; fifth write ignored; then ack four times -> memory sees addr 1,2,3,4 in order.
REQ-033 Writes 0x0005/0x11 then 0x0005/0x22, rd_address=0x0005 -> fwd_hit=1, fwd_data=0x22 (with macro: count=1 after second write if head not draining; without: count=2).
REQ-034 Full buffer, wr_req and mem_ack in same cycle -> pop only, count=3, written data not stored.
REQ-035 rst asserted while mem_write=1 and count=3 -> immediately mem_write=0, count=0, empty=1; late mem_ack after release ignored.
REQ-036 Pointer wrap: 10 write/drain pairs with DEPTH=4 -> memory receives all 10 in order, no loss or duplication.
